i2s_frame_tx: RTL and testbench

- Downstream consumer of the RPi serial receiver; replaces the separate data_shift / clk_div / interrupt glue with one single-clock stage.
- Buffers 16-bit PCM words in a small FIFO and generates bclk, lrclk and the I2S serial data line.
- Uses 1-bit I2S delay and MSB-first order.
- Raises need_data to the RPi when the buffer runs low.

---
 rtl/i2s_frame_tx.sv | 160 ++++++++++++++++
 tb/tb_i2s_frame_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_tx.sv
// rtl/i2s_frame_tx.sv - PCM word FIFO feeding a 1-bit-delay MSB-first I2S transmitter
module i2s_frame_tx #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int BCLK_DIV  = 4,
  parameter int LOW_WATER = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     bclk,
  output logic                     lrclk,
  output logic                     sdata,
  output logic                     need_data,
  output logic                     underrun,
  input  logic                     underrun_clr,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int SLOTS  = 2 * WIDTH;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int HC_W   = $clog2(BCLK_DIV);

  // bit-clock divider
  logic [HC_W-1:0]    half_cnt;
  logic               half_tc;
  logic               fall_evt;

  // serializer
  logic [SLOT_W-1:0]  slot;
  logic [SLOT_W-1:0]  slot_next;
  logic               frame_end;
  logic [SLOTS-1:0]   frame;
  logic [SLOTS-1:0]   frame_src;
  logic               delay_bit;

  // word buffer
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   level_nxt;

  // frame-boundary decisions
  logic               load_evt;
  logic               have_pair;
  logic               pop;
  logic               starve;
  logic               push;

  assign half_tc   = (half_cnt == HC_W'(BCLK_DIV - 1));
  // a falling edge is a divider wrap while bclk is currently high
  assign fall_evt  = half_tc && bclk;
  assign frame_end = (slot == SLOT_W'(SLOTS - 1));
  assign slot_next = frame_end ? '0 : slot + SLOT_W'(1);

  assign load_evt  = fall_evt && frame_end;
  assign have_pair = (level >= LVL_W'(2));
  assign pop       = load_evt && have_pair;
  assign starve    = load_evt && !have_pair;

  assign in_ready   = (level < LVL_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_level = level;

  // frame used by this edge's shift: a fresh {L,R} pair, silence when starved, else the running frame
  always_comb begin
    frame_src = frame;
    if (pop) begin
      frame_src = {mem[rd_ptr], mem[rd_ptr + PTR_W'(1)]};
    end else if (starve) begin
      frame_src = '0;
    end
  end

  // occupancy after this cycle's push and pair pop
  always_comb begin
    level_nxt = level;
    if (push) begin
      level_nxt = level_nxt + LVL_W'(1);
    end
    if (pop) begin
      level_nxt = level_nxt - LVL_W'(2);
    end
  end

  // bit clock: toggle every BCLK_DIV system clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      bclk     <= 1'b0;
    end else if (half_tc) begin
      half_cnt <= '0;
      bclk     <= ~bclk;
    end else begin
      half_cnt <= half_cnt + HC_W'(1);
    end
  end

  // slot/word-select and data shift, all updated on bclk falling edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= '0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      delay_bit <= 1'b0;
      frame     <= '0;
    end else if (fall_evt) begin
      slot      <= slot_next;
      lrclk     <= (slot_next >= SLOT_W'(WIDTH));
      sdata     <= delay_bit;
      delay_bit <= frame_src[SLOTS-1];
      frame     <= {frame_src[SLOTS-2:0], 1'b0};
    end
  end

  // FIFO pointers and occupancy; pops always take a whole L/R pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(2);
      end
      level <= level_nxt;
    end
  end

  // FIFO storage; contents are meaningless once pointers reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // status flags: low-water request and sticky starvation flag (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      need_data <= 1'b1;
      underrun  <= 1'b0;
    end else begin
      need_data <= (level_nxt <= LVL_W'(LOW_WATER));
      if (starve) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_tx.sv
// tb/tb_i2s_frame_tx.sv - scoreboard bench for i2s_frame_tx against a stream-level model
module tb_i2s_frame_tx;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 8;
  localparam int BCLK_DIV  = 4;
  localparam int LOW_WATER = 2;
  localparam int SLOTS     = 2 * WIDTH;
  localparam int FRAME_CLK = 2 * BCLK_DIV * SLOTS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             bclk;
  logic             lrclk;
  logic             sdata;
  logic             need_data;
  logic             underrun;
  logic             underrun_clr = 1'b0;
  logic [3:0]       fifo_level;

  always #5 clk = ~clk;

  i2s_frame_tx #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BCLK_DIV(BCLK_DIV), .LOW_WATER(LOW_WATER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .need_data(need_data), .underrun(underrun), .underrun_clr(underrun_clr),
    .fifo_level(fifo_level)
  );

  int total = 0;
  int bad = 0;

  // reference model state: clocks since reset, queued words, expected serial stream
  int               cyc = 0;
  logic [WIDTH-1:0] wq[$];
  bit               eb[$];
  bit               und_m = 1'b0;
  bit               last_acc = 1'b0;
  int               m_lvl;
  logic [SLOTS-1:0] m_fr;
  bit               m_wrap;
  bit               mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d t=%0t", name, act, exp, cyc, $time);
    end
  endtask

  // stream = one idle delay bit, then every frame MSB-first; first frame is silence
  function automatic void model_reset();
    cyc = 0;
    wq.delete();
    eb.delete();
    for (int i = 0; i < 1 + SLOTS; i++) eb.push_back(1'b0);
    und_m = 1'b0;
    last_acc = 1'b0;
  endfunction

  // model: frame boundary every FRAME_CLK clocks takes an L/R pair or plays silence
  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      m_lvl = wq.size();
      last_acc = in_valid && (m_lvl < DEPTH);
      m_wrap = (cyc % FRAME_CLK) == 0;
      m_fr = '0;
      if (m_wrap && m_lvl >= 2) begin
        m_fr[SLOTS-1:WIDTH] = wq.pop_front();
        m_fr[WIDTH-1:0]     = wq.pop_front();
      end
      if (m_wrap) begin
        for (int i = SLOTS - 1; i >= 0; i--) eb.push_back(m_fr[i]);
      end
      if (m_wrap && m_lvl < 2) und_m = 1'b1;
      else if (underrun_clr) und_m = 1'b0;
      if (last_acc) wq.push_back(in_data);
    end
  end

  // per-cycle checks of clocks and status against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("bclk", bclk, (cyc / BCLK_DIV) % 2);
      chk("lrclk", lrclk, ((cyc / (2 * BCLK_DIV)) % SLOTS) >= WIDTH);
      chk("fifo_level", fifo_level, wq.size());
      chk("in_ready", in_ready, wq.size() < DEPTH);
      chk("need_data", need_data, wq.size() <= LOW_WATER);
      chk("underrun", underrun, und_m);
    end
  end

  // serial data monitor: one expected bit per bclk rising edge
  always @(posedge bclk) begin
    #1;
    if (rst_n) begin
      if (eb.size() == 0) begin
        chk("sdata_queue_empty", 1'b1, 1'b0);
      end else begin
        mon_exp = eb.pop_front();
        chk("sdata", sdata, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    underrun_clr = 1'b0;
    #1;
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_need_data", need_data, 1);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_in_ready", in_ready, 1);
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 2 * FRAME_CLK);
    if (!last_acc) chk("push_timeout", 1'b1, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic wait_mod(input int m);
    int n;
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 2 * FRAME_CLK) begin
      tick();
      n++;
      if ((cyc % FRAME_CLK) == m) hit = 1'b1;
    end
    if (!hit) chk("wait_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    do_reset();

    // idle: silent first frame, starvation flagged at the first boundary
    repeat (300) tick();
    chk("idle_underrun", underrun, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("clr_underrun", underrun, 0);

    // known pair into the next frame
    push_word(16'hA5F0);
    push_word(16'h0FF1);
    chk("pair_level", fifo_level, 2);
    wait_mod(1);
    chk("pair_popped", fifo_level, 0);
    chk("pair_no_underrun", underrun, 0);

    // fill to full; ninth word waits for the next pair pop
    for (int i = 0; i < DEPTH; i++) push_word(WIDTH'($urandom));
    chk("full_level", fifo_level, DEPTH);
    chk("full_ready", in_ready, 0);
    push_word(WIDTH'($urandom));
    chk("ninth_accepted_level", fifo_level, DEPTH - 1);

    // drain to the odd leftover, then clear / same-cycle clear against starvation
    repeat (5 * FRAME_CLK) tick();
    chk("odd_leftover", fifo_level, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("und_cleared", underrun, 0);
    wait_mod(FRAME_CLK - 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("und_set_wins", underrun, 1);
    tick();
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("und_later_clear", underrun, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data = WIDTH'($urandom);
      underrun_clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 1'b0;
    underrun_clr = 1'b0;

    // reset mid-frame with five words queued
    repeat (5 * FRAME_CLK) tick();
    wait_mod(100);
    for (int i = 0; i < DEPTH && wq.size() < 7; i++) push_word(WIDTH'($urandom));
    wait_mod(0);
    wait_mod(9 * 2 * BCLK_DIV + 3);
    chk("pre_reset_level", fifo_level, 5);
    do_reset();
    repeat (FRAME_CLK + 50) tick();
    chk("post_reset_underrun", underrun, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
